// File: rtl/decode_unit_pkg.sv
// rtl/decode_unit_pkg.sv - ISA opcodes, ALU codes, FSM state codes and control bundle type
package decode_unit_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h5;
    localparam logic [3:0] OP_SW   = 4'h6;
    localparam logic [3:0] OP_BEQ  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_LDI  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_PASSB = 3'd4;

    localparam logic [0:0] S_RUN = 1'b0;
    localparam logic [0:0] S_EXT = 1'b1;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       use_imm;
        logic       reg_we;
        logic       mem_rd;
        logic       mem_wr;
        logic       branch;
        logic       jump;
        logic       illegal;
        logic       halt;
    } ctrl_t;

endpackage

// File: rtl/decode_unit_instr_fields.sv
// rtl/decode_unit_instr_fields.sv - combinational opcode to control-strobe table
module decode_unit_instr_fields
    import decode_unit_pkg::*;
(
    input  logic [3:0] op,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (op)
            OP_ADD:  begin ctrl.alu_op = ALU_ADD; ctrl.reg_we = 1'b1; end
            OP_SUB:  begin ctrl.alu_op = ALU_SUB; ctrl.reg_we = 1'b1; end
            OP_AND:  begin ctrl.alu_op = ALU_AND; ctrl.reg_we = 1'b1; end
            OP_OR:   begin ctrl.alu_op = ALU_OR;  ctrl.reg_we = 1'b1; end
            OP_ADDI: begin ctrl.alu_op = ALU_ADD; ctrl.use_imm = 1'b1; ctrl.reg_we = 1'b1; end
            OP_LW:   begin
                ctrl.alu_op  = ALU_ADD;
                ctrl.use_imm = 1'b1;
                ctrl.reg_we  = 1'b1;
                ctrl.mem_rd  = 1'b1;
            end
            OP_SW:   begin ctrl.alu_op = ALU_ADD; ctrl.use_imm = 1'b1; ctrl.mem_wr = 1'b1; end
            OP_BEQ:  begin ctrl.alu_op = ALU_SUB; ctrl.branch = 1'b1; end
            OP_JMP:  ctrl.jump = 1'b1;
            OP_LDI:  begin ctrl.alu_op = ALU_PASSB; ctrl.reg_we = 1'b1; end
            OP_HALT: ctrl.halt = 1'b1;
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_unit.sv
// rtl/decode_unit.sv - registered decode stage with LDI assembly FSM, flush and sticky halt
module decode_unit
    import decode_unit_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 6,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [DATA_W-1:0] instr,
    input  logic              flush,
    output logic              id_valid,
    input  logic              ex_ready,
    output logic [REG_AW-1:0] rd,
    output logic [REG_AW-1:0] rs1,
    output logic [REG_AW-1:0] rs2,
    output logic [IMM_W-1:0]  const_out,
    output logic [DATA_W-1:0] imm16,
    output logic [2:0]        alu_op,
    output logic              use_imm,
    output logic              reg_we,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              branch,
    output logic              jump,
    output logic              illegal,
    output logic              halt
);

    logic [0:0]        state;
    logic              halted;
    logic [DATA_W-1:0] pend_word;
    logic [DATA_W-1:0] dec_word;
    logic              accept;
    logic              ldi_first;
    logic              emit;
    ctrl_t             ctrl;

    assign if_ready = ~halted & (~id_valid | ex_ready);
    assign accept   = if_valid & if_ready & ~flush;

    // In S_EXT the bundle is decoded from the held first word; the incoming word is only data.
    assign dec_word  = (state == S_EXT) ? pend_word : instr;
    assign ldi_first = (state == S_RUN) && (instr[15:12] == OP_LDI);
    assign emit      = accept & ~ldi_first;

    decode_unit_instr_fields u_fields (
        .op   (dec_word[15:12]),
        .ctrl (ctrl)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RUN;
            halted    <= 1'b0;
            pend_word <= '0;
            id_valid  <= 1'b0;
            rd        <= '0;
            rs1       <= '0;
            rs2       <= '0;
            const_out <= '0;
            imm16     <= '0;
            alu_op    <= '0;
            use_imm   <= 1'b0;
            reg_we    <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            branch    <= 1'b0;
            jump      <= 1'b0;
            illegal   <= 1'b0;
            halt      <= 1'b0;
        end else if (flush) begin
            id_valid <= 1'b0;
            state    <= S_RUN;
        end else begin
            if (accept && ldi_first) begin
                pend_word <= instr;
                state     <= S_EXT;
            end
            if (emit) begin
                rd        <= dec_word[11:9];
                rs1       <= dec_word[8:6];
                rs2       <= dec_word[5:3];
                const_out <= dec_word[5:0];
                imm16     <= (state == S_EXT) ? instr : '0;
                alu_op    <= ctrl.alu_op;
                use_imm   <= ctrl.use_imm;
                reg_we    <= ctrl.reg_we;
                mem_rd    <= ctrl.mem_rd;
                mem_wr    <= ctrl.mem_wr;
                branch    <= ctrl.branch;
                jump      <= ctrl.jump;
                illegal   <= ctrl.illegal;
                halt      <= ctrl.halt;
                state     <= S_RUN;
                if (ctrl.halt) begin
                    halted <= 1'b1;
                end
            end
            if (emit) begin
                id_valid <= 1'b1;
            end else if (ex_ready) begin
                id_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_unit.sv
// tb/tb_decode_unit.sv - directed self-checking bench for decode_unit
module tb_decode_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic        if_ready;
    logic [15:0] instr;
    logic        flush;
    logic        id_valid;
    logic        ex_ready;
    logic [2:0]  rd, rs1, rs2;
    logic [5:0]  const_out;
    logic [15:0] imm16;
    logic [2:0]  alu_op;
    logic        use_imm, reg_we, mem_rd, mem_wr, branch, jump, illegal, halt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    decode_unit dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .instr(instr),
        .flush(flush), .id_valid(id_valid), .ex_ready(ex_ready), .rd(rd), .rs1(rs1), .rs2(rs2),
        .const_out(const_out), .imm16(imm16), .alu_op(alu_op), .use_imm(use_imm), .reg_we(reg_we),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .branch(branch), .jump(jump), .illegal(illegal), .halt(halt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_valid = 1'b0; instr = 16'h0; flush = 1'b0; ex_ready = 1'b1;
        step(); step();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid got=%b exp=0", id_valid); end
        checks++; if ({rd, rs1, rs2, const_out, imm16, alu_op} !== 37'h0) begin errors++; $display("FAIL reset_fields got=%h exp=0", {rd, rs1, rs2, const_out, imm16, alu_op}); end
        checks++; if ({use_imm, reg_we, mem_rd, mem_wr, branch, jump, illegal, halt} !== 8'h0) begin errors++; $display("FAIL reset_strobes got=%b exp=0", {use_imm, reg_we, mem_rd, mem_wr, branch, jump, illegal, halt}); end
        rst = 1'b0;
        step();
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL reset_if_ready got=%b exp=1", if_ready); end
    endtask

    task automatic test_addi();
        if_valid = 1'b1; instr = 16'h42BD; ex_ready = 1'b1;
        step();
        if_valid = 1'b0;
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL addi_id_valid got=%b exp=1", id_valid); end
        checks++; if ({rd, rs1} !== {3'd1, 3'd2}) begin errors++; $display("FAIL addi_regs got=%0d,%0d exp=1,2", rd, rs1); end
        checks++; if (const_out !== 6'h3D) begin errors++; $display("FAIL addi_const got=%h exp=3d", const_out); end
        checks++; if ({use_imm, reg_we, alu_op} !== {1'b1, 1'b1, 3'd0}) begin errors++; $display("FAIL addi_ctrl got=%b exp=11000", {use_imm, reg_we, alu_op}); end
        step();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL addi_drain got=%b exp=0", id_valid); end
    endtask

    task automatic test_ldi();
        if_valid = 1'b1; instr = 16'h9600; ex_ready = 1'b1;
        step();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL ldi_word1_silent got=%b exp=0", id_valid); end
        instr = 16'hBEEF;
        step();
        if_valid = 1'b0;
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL ldi_id_valid got=%b exp=1", id_valid); end
        checks++; if (rd !== 3'd3) begin errors++; $display("FAIL ldi_rd got=%0d exp=3", rd); end
        checks++; if (imm16 !== 16'hBEEF) begin errors++; $display("FAIL ldi_imm16 got=%h exp=beef", imm16); end
        checks++; if ({alu_op, reg_we, halt, illegal} !== {3'd4, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL ldi_ctrl got=%b exp=100100", {alu_op, reg_we, halt, illegal}); end
        step();
    endtask

    task automatic test_stall();
        if_valid = 1'b1; instr = 16'h0298; ex_ready = 1'b0;
        step();
        instr = 16'h3000;
        for (int i = 0; i < 3; i++) begin
            checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL stall_if_ready[%0d] got=%b exp=0", i, if_ready); end
            checks++; if ({id_valid, rd, rs1, rs2, alu_op} !== {1'b1, 3'd1, 3'd2, 3'd3, 3'd0}) begin errors++; $display("FAIL stall_hold[%0d] got=%h exp=%h", i, {id_valid, rd, rs1, rs2, alu_op}, {1'b1, 3'd1, 3'd2, 3'd3, 3'd0}); end
            step();
        end
        ex_ready = 1'b1;
        #1;
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL stall_release got=%b exp=1", if_ready); end
        step();
        if_valid = 1'b0;
        checks++; if ({id_valid, rd, alu_op} !== {1'b1, 3'd0, 3'd3}) begin errors++; $display("FAIL stall_next got=%h exp=%h", {id_valid, rd, alu_op}, {1'b1, 3'd0, 3'd3}); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [15:0] seq [4];
        seq[0] = 16'h0000; seq[1] = 16'h1000; seq[2] = 16'h2000; seq[3] = 16'h3000;
        ex_ready = 1'b1; if_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            instr = seq[i];
            checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, if_ready); end
            step();
            checks++; if ({id_valid, alu_op} !== {1'b1, 3'(i)}) begin errors++; $display("FAIL b2b_op[%0d] got=%h exp=%h", i, {id_valid, alu_op}, {1'b1, 3'(i)}); end
        end
        if_valid = 1'b0;
        step();
    endtask

    task automatic test_flush();
        if_valid = 1'b1; instr = 16'h9600; ex_ready = 1'b1;
        step();
        flush = 1'b1; instr = 16'h1298;
        step();
        flush = 1'b0;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL flush_id_valid got=%b exp=0", id_valid); end
        step();
        if_valid = 1'b0;
        checks++; if ({id_valid, rd, rs1, rs2} !== {1'b1, 3'd1, 3'd2, 3'd3}) begin errors++; $display("FAIL flush_sub_regs got=%h exp=%h", {id_valid, rd, rs1, rs2}, {1'b1, 3'd1, 3'd2, 3'd3}); end
        checks++; if ({alu_op, imm16} !== {3'd1, 16'h0}) begin errors++; $display("FAIL flush_sub_op got=%h exp=%h", {alu_op, imm16}, {3'd1, 16'h0}); end
        step();
    endtask

    task automatic test_illegal_halt();
        if_valid = 1'b1; instr = 16'hA000; ex_ready = 1'b1;
        step();
        checks++; if ({id_valid, illegal, reg_we, mem_rd, mem_wr, branch, jump, halt} !== 8'b1100_0000) begin errors++; $display("FAIL illegal_ctrl got=%b exp=11000000", {id_valid, illegal, reg_we, mem_rd, mem_wr, branch, jump, halt}); end
        instr = 16'hF000;
        step();
        instr = 16'h0000;
        checks++; if ({id_valid, halt, illegal, reg_we} !== 4'b1100) begin errors++; $display("FAIL halt_ctrl got=%b exp=1100", {id_valid, halt, illegal, reg_we}); end
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL halt_ready_now got=%b exp=0", if_ready); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        step(); step();
        checks++; if ({if_ready, id_valid} !== 2'b00) begin errors++; $display("FAIL halt_sticky got=%b exp=00", {if_ready, id_valid}); end
        if_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        checks++; if ({if_ready, halt} !== 2'b10) begin errors++; $display("FAIL halt_cleared got=%b exp=10", {if_ready, halt}); end
    endtask

    task automatic test_reset_mid_ldi();
        if_valid = 1'b1; instr = 16'h9600; ex_ready = 1'b1;
        step();
        if_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if ({id_valid, rd, alu_op, reg_we, imm16} !== 24'h0) begin errors++; $display("FAIL rst_ext_outputs got=%h exp=0", {id_valid, rd, alu_op, reg_we, imm16}); end
        step();
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL rst_ext_ready got=%b exp=1", if_ready); end
        if_valid = 1'b1; instr = 16'h42BD;
        step();
        if_valid = 1'b0;
        checks++; if ({id_valid, rd, rs1, const_out, use_imm, reg_we, alu_op} !== {1'b1, 3'd1, 3'd2, 6'h3D, 1'b1, 1'b1, 3'd0}) begin errors++; $display("FAIL rst_ext_addi got=%h exp=%h", {id_valid, rd, rs1, const_out, use_imm, reg_we, alu_op}, {1'b1, 3'd1, 3'd2, 6'h3D, 1'b1, 1'b1, 3'd0}); end
        checks++; if (imm16 !== 16'h0) begin errors++; $display("FAIL rst_ext_imm16 got=%h exp=0", imm16); end
        step();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_ldi();
        test_stall();
        test_back_to_back();
        test_flush();
        test_illegal_halt();
        test_reset_mid_ldi();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
